// File: rtl/oled_spi_stream.sv
// SSD1331-class OLED link: panel reset pulse, fixed init command stream, then
// RGB565 pixels serialised as two SPI mode-0 data bytes with (x, y) tracking.
module oled_spi_stream #(
    parameter int CLK_DIV      = 2,
    parameter int RESET_CYCLES = 1000,
    parameter int WIDTH        = 96,
    parameter int HEIGHT       = 64
) (
    input  logic        clki,
    input  logic        rstn,
    input  logic [15:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic [6:0]  pixel_x,
    output logic [5:0]  pixel_y,
    output logic        init_done,
    output logic        oled_csn,
    output logic        oled_clk,
    output logic        oled_mosi,
    output logic        oled_dc,
    output logic        oled_resn
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
    localparam logic [5:0]       Y_LAST   = 6'(HEIGHT - 1);
    localparam logic [3:0]       INIT_LEN = 4'd15;

    localparam logic [2:0] S_RST_LO   = 3'd0;
    localparam logic [2:0] S_RST_WAIT = 3'd1;
    localparam logic [2:0] S_INIT     = 3'd2;
    localparam logic [2:0] S_IDLE     = 3'd3;
    localparam logic [2:0] S_SEND_HI  = 3'd4;
    localparam logic [2:0] S_SEND_LO  = 3'd5;

    localparam logic [1:0] E_IDLE = 2'd0;
    localparam logic [1:0] E_LOW  = 2'd1;
    localparam logic [1:0] E_HIGH = 2'd2;
    localparam logic [1:0] E_GAP  = 2'd3;

    function automatic logic [7:0] init_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    init_rom = 8'hAE;
            4'd1:    init_rom = 8'hA0;
            4'd2:    init_rom = 8'h72;
            4'd3:    init_rom = 8'hA1;
            4'd4:    init_rom = 8'h00;
            4'd5:    init_rom = 8'hA2;
            4'd6:    init_rom = 8'h00;
            4'd7:    init_rom = 8'hA4;
            4'd8:    init_rom = 8'hA8;
            4'd9:    init_rom = 8'h3F;
            4'd10:   init_rom = 8'hAD;
            4'd11:   init_rom = 8'h8E;
            4'd12:   init_rom = 8'hB0;
            4'd13:   init_rom = 8'h0B;
            4'd14:   init_rom = 8'hAF;
            default: init_rom = 8'h00;
        endcase
    endfunction

    logic [2:0]       state_q, state_d;
    logic [RST_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rom_idx_q, rom_idx_d;
    logic [7:0]       pix_lo_q, pix_lo_d;
    logic [6:0]       x_q, x_d;
    logic [5:0]       y_q, y_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             resn_q, resn_d;

    logic [1:0]       eng_q, eng_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       sh_q, sh_d;
    logic             csn_q, csn_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             dc_q, dc_d;

    logic             start;
    logic [7:0]       start_byte;
    logic             start_dc;
    logic             div_last;
    logic             eng_done;

    assign div_last = (div_q == DIV_LAST);
    // eng_done marks the last gap cycle; a byte started on that edge keeps a 17*CLK_DIV slot
    assign eng_done = (eng_q == E_GAP) && div_last;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_idx_d  = rom_idx_q;
        pix_lo_d   = pix_lo_q;
        x_d        = x_q;
        y_d        = y_q;
        ready_d    = ready_q;
        done_d     = done_q;
        resn_d     = resn_q;
        start      = 1'b0;
        start_byte = 8'h00;
        start_dc   = 1'b0;
        case (state_q)
            S_RST_LO: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    resn_d  = 1'b1;
                    state_d = S_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d      = '0;
                    start      = 1'b1;
                    start_byte = init_rom(4'd0);
                    rom_idx_d  = 4'd1;
                    state_d    = S_INIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INIT: begin
                if (eng_done) begin
                    if (rom_idx_q == INIT_LEN) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        start      = 1'b1;
                        start_byte = init_rom(rom_idx_q);
                        rom_idx_d  = rom_idx_q + 4'd1;
                    end
                end
            end
            S_IDLE: begin
                if (pixel_valid && ready_q) begin
                    ready_d    = 1'b0;
                    pix_lo_d   = pixel_data[7:0];
                    start      = 1'b1;
                    start_byte = pixel_data[15:8];
                    start_dc   = 1'b1;
                    state_d    = S_SEND_HI;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = (y_q == Y_LAST) ? '0 : y_q + 6'd1;
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                end
            end
            S_SEND_HI: begin
                if (eng_done) begin
                    start      = 1'b1;
                    start_byte = pix_lo_q;
                    start_dc   = 1'b1;
                    state_d    = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (eng_done) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_RST_LO;
        endcase
    end

    // Byte engine: MSB first, mosi only moves on the low-going clock edge.
    always_comb begin
        eng_d  = eng_q;
        div_d  = div_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        csn_d  = csn_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        dc_d   = dc_q;
        case (eng_q)
            E_LOW: begin
                if (div_last) begin
                    div_d  = '0;
                    sclk_d = 1'b1;
                    eng_d  = E_HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            E_HIGH: begin
                if (div_last) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 3'd0) begin
                        mosi_d = 1'b0;
                        csn_d  = 1'b1;
                        eng_d  = E_GAP;
                    end else begin
                        bit_d  = bit_q - 3'd1;
                        mosi_d = sh_q[6];
                        sh_d   = {sh_q[5:0], 1'b0};
                        eng_d  = E_LOW;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            E_GAP: begin
                if (div_last) begin
                    div_d = '0;
                    eng_d = E_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (start) begin
            eng_d  = E_LOW;
            div_d  = '0;
            bit_d  = 3'd7;
            sh_d   = start_byte[6:0];
            csn_d  = 1'b0;
            sclk_d = 1'b0;
            mosi_d = start_byte[7];
            dc_d   = start_dc;
        end
    end

    always_ff @(posedge clki) begin
        if (!rstn) begin
            state_q   <= S_RST_LO;
            cnt_q     <= '0;
            rom_idx_q <= '0;
            pix_lo_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            resn_q    <= 1'b0;
            eng_q     <= E_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            csn_q     <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            dc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rom_idx_q <= rom_idx_d;
            pix_lo_q  <= pix_lo_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            resn_q    <= resn_d;
            eng_q     <= eng_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            csn_q     <= csn_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            dc_q      <= dc_d;
        end
    end

    assign pixel_ready = ready_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign init_done   = done_q;
    assign oled_csn    = csn_q;
    assign oled_clk    = sclk_q;
    assign oled_mosi   = mosi_q;
    assign oled_dc     = dc_q;
    assign oled_resn   = resn_q;

endmodule

// File: doc/oled_spi_stream.md
Name: oled_spi_stream

Overview:
- OLED link stage between the pattern/pixel generator and the SSD1331-class 96x64 panel's SPI pins.
- Drives the panel hardware reset pulse, then sends a fixed init command sequence.
- Then accepts RGB565 pixels over a valid/ready handshake and serialises each pixel as two data bytes.
- Publishes the (x, y) coordinate of the next pixel it will accept, so the upstream generator can compute it.

Parameters:
- CLK_DIV, 2: clki cycles per SPI clock half-period; must be ≥1.
- RESET_CYCLES, 1000: clki cycles for each of the resn-low phase and the post-reset wait phase.
- WIDTH, 96: pixels per line.
- HEIGHT, 64: lines per frame.

Ports:
- clki  input  1  system clock; all logic on its rising edge.
- rstn  input  1  reset; synchronous, active-low.
- pixel_data  input  16  RGB565 pixel, MSB-first on the wire.
- pixel_valid  input  1  upstream has a pixel.
- pixel_ready  output  1  block accepts pixel_data this cycle.
- pixel_x  output  7  column of the next pixel to be accepted (0..WIDTH-1).
- pixel_y  output  6  row of the next pixel to be accepted (0..HEIGHT-1).
- init_done  output  1  init sequence complete; stays high until reset.
- oled_csn  output  1  SPI chip select, active-low.
- oled_clk  output  1  SPI clock, mode 0.
- oled_mosi  output  1  SPI data.
- oled_dc  output  1  0 = command byte, 1 = data byte.
- oled_resn  output  1  panel reset, active-low.

Behaviour:
- Reset (rstn=0 at a clki edge), all outputs registered:
  - oled_csn=1, oled_clk=0, oled_mosi=0, oled_dc=0, oled_resn=0.
  - pixel_ready=0, init_done=0, pixel_x=0, pixel_y=0.
  - FSM goes to RST_LO.
  - Applies from any state, including mid-byte: the current byte is abandoned and the full sequence restarts.
- FSM states: RST_LO → RST_WAIT → INIT → IDLE ⇄ SEND_HI → SEND_LO → IDLE.
- RST_LO: oled_resn=0 for RESET_CYCLES cycles, then oled_resn=1 and go to RST_WAIT.
- RST_WAIT: hold RESET_CYCLES cycles with csn=1, then go to INIT.
- INIT:
  - Sends 15 ROM bytes in order, all with dc=0: AE A0 72 A1 00 A2 00 A4 A8 3F AD 8E B0 0B AF.
  - After the last byte's gap: init_done=1, go to IDLE.
- Byte engine (shared by INIT and pixel sends):
  - Load cycle: csn←0, dc←byte type, mosi←bit7, clk←0.
  - Each bit: clk low CLK_DIV cycles, then high CLK_DIV cycles. mosi changes only while clk is low, at the start of the bit.
  - After bit0's high half: clk←0, mosi←0, csn←1 for CLK_DIV gap cycles.
  - csn low for exactly 16·CLK_DIV cycles per byte; byte slot is 17·CLK_DIV cycles.
  - The next byte loads in the cycle immediately after the gap.
  - dc is stable for the whole time csn is low.
- IDLE:
  - pixel_ready=1 only in IDLE with init_done=1.
  - Accept when pixel_valid && pixel_ready: latch pixel_data, deassert ready next cycle, advance coordinates, go to SEND_HI.
  - The first byte loads on the cycle after accept.
  - pixel_valid while ready=0 is ignored; pixel_data is sampled only at accept.
  - With no valid, outputs idle: csn=1, clk=0.
- SEND_HI: sends pixel[15:8] with dc=1.
- SEND_LO: sends pixel[7:0] with dc=1, then returns to IDLE; ready=1 on the cycle after the gap ends.
- Pixel period under continuous valid: 34·CLK_DIV+1 cycles.
- Coordinates:
  - Update on accept: x+1.
  - If x=WIDTH-1: x←0, y+1.
  - If additionally y=HEIGHT-1: y←0 (frame wrap).
  - No other events move x or y.

Test Plan:
1. Reset timing (CLK_DIV=2, RESET_CYCLES=16): rstn low 3 cycles → all outputs at reset values. Then release → oled_resn=0 for 16 cycles, then 1; first csn fall exactly 16 cycles later.
2. Init capture: SPI model samples mosi on clk rising while csn=0 → 15 bytes AE A0 72 A1 00 A2 00 A4 A8 3F AD 8E B0 0B AF, all dc=0. Each csn-low window is 32 cycles with a 2-cycle gap; init_done rises after the final gap; pixel_ready=1 the same cycle.
3. Single pixel 16'hF81F → bytes F8 then 1F, dc=1. pixel_ready low 68 cycles and high again on the 69th. pixel_x goes 0→1 on the accept cycle.
4. Continuous valid for 6144 pixels → coordinates step (0,0),(1,0)…(95,0),(0,1)…(95,63), then back to (0,0). The SPI model receives 12288 data bytes matching the stimulus.
5. Backpressure: pixel_valid=0 for 200 cycles after init → csn=1, clk=0, coordinates unchanged. Then valid=1 with data 16'h1234 → bytes 12 34.
6. Reset mid-byte: rstn=0 during bit 3 of SEND_HI → next cycle csn=1, clk=0, oled_resn=0, init_done=0, x=y=0. After release the full reset+init sequence repeats identically to scenario 2.
